ahbl_uart_rx: RTL and testbench
===============================

Name: ahbl_uart_rx

Overview:
- AHB-Lite slave UART receiver: 8N1 serial input, on-chip FIFO, level interrupt.
- Companion to the SoC's UART transmitter; occupies its own crossbar slave port.
- The CPU, and later the DMAC, read received bytes over the bus.

Parameters:
- FIFO_DEPTH, 16, receive FIFO entries; power of two, 2..256.
- DEF_PRESCALE, 16'd868, reset value of PRESCALE (clocks per bit; 100 MHz / 115200).

Ports:
- HCLK  input  1  system clock.
- HRESETn  input  1  asynchronous active-low reset.
- HSEL  input  1  slave select.
- HADDR  input  32  address; only [3:2] decoded.
- HTRANS  input  2  transfer type; bit 1 set = active.
- HSIZE  input  3  ignored; all accesses treated as word.
- HWRITE  input  1  write strobe.
- HREADY  input  1  bus ready.
- HWDATA  input  32  write data.
- HREADYOUT  output  1  constant 1; no wait states.
- HRDATA  output  32  read data.
- rx  input  1  serial line; idle high; asynchronous.
- IRQ  output  1  receive interrupt, level.

Behaviour:
- Reset values:
  - HRDATA=0, IRQ=0, CTRL=0, PRESCALE=DEF_PRESCALE.
  - FIFO empty, sticky flags clear, FSM in IDLE.
  - rx synchroniser flops reset to 1.
- Bus timing:
  - Address phase is accepted when HSEL & HREADY & HTRANS[1].
  - HADDR[3:2] and HWRITE are registered at acceptance.
  - Writes take effect from HWDATA in the following cycle.
  - Read data is registered at acceptance and driven on HRDATA for the whole data phase.
  - Unused register bits read 0.
- Register map (byte offsets):
  - 0x0 DATA (RO): {24'b0, head byte}. Reading while FIFO non-empty pops the head at address-phase acceptance. Reading while empty returns 0 with no pop.
  - 0x4 STATUS: bit0 NOT_EMPTY, bit1 FULL, bit2 OVERRUN (sticky), bit3 FRAME_ERR (sticky), bits[12:4] fill level. Writing 1 to bit2 or bit3 clears that flag.
  - 0x8 CTRL (RW): bit0 EN, bit1 IRQ_EN.
  - 0xC PRESCALE (RW): [15:0] clocks per bit. An effective value below 4 is treated as 4.
- Input synchronisation:
  - rx passes through a 2-flop synchroniser.
  - Start edge = synchronised rx low while the previous synchronised sample was high.
- Receive FSM, with counter cnt[15:0] and bit index[2:0]:
  - IDLE: on start edge with EN=1, load cnt=PRESCALE/2 and go to START.
  - START: when cnt reaches 0, sample rx. If low: load cnt=PRESCALE-1, index=0, go to DATA. If high: false start, return to IDLE.
  - DATA: when cnt reaches 0, shift rx into the shift register LSB-first and reload cnt. After index 7, go to STOP.
  - STOP: when cnt reaches 0, sample rx. If high: push byte, go to IDLE. If low: set FRAME_ERR, discard byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until synchronised rx=1, then go to IDLE.
- Latency: the byte is pushed about 9.5 bit times after the start edge, measured at the stop-bit midpoint.
- FIFO boundaries:
  - Push when full with no pop in the same cycle: byte dropped, OVERRUN set.
  - Push and pop in the same cycle: both occur; level unchanged, including when full.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Enable and reprogramming:
  - Clearing EN mid-frame forces the FSM to IDLE and discards the partial byte. FIFO contents and flags are kept.
  - A PRESCALE write mid-frame takes effect at the next counter reload.
- IRQ:
  - IRQ = IRQ_EN & (NOT_EMPTY | OVERRUN | FRAME_ERR), registered.
  - It deasserts one cycle after the condition clears.
- Reset mid-frame: all state returns to reset values immediately (asynchronous); a partial byte is lost.

Test Plan:
- Basic receive: PRESCALE=16, EN=1, IRQ_EN=1, drive byte 0xA5 8N1 → STATUS=0x11, IRQ=1. Read DATA → 0x000000A5; then STATUS=0x00 and IRQ falls one cycle later.
- FIFO fill: send 17 bytes 0x00..0x10 without reads → STATUS FULL=1, OVERRUN=1, level=16. Sixteen reads return 0x00..0x0F in order; a 17th read returns 0. Write STATUS=0x4 → OVERRUN=0.
- Frame error: send 0x3C with stop bit held low for 2 bit times → FRAME_ERR=1, FIFO still empty. A following valid 0x55 is received correctly once rx has returned high.
- False start: 3-cycle low glitch on rx with PRESCALE=16 → FSM returns to IDLE, no push, no flags set.
- Simultaneous push and pop: FIFO full with 16 bytes; issue a DATA read in the same cycle as a stop-bit push → level stays 16, OVERRUN=0, new byte is at the tail.
- Disable mid-frame, then reset: clear EN during bit 4 → no push; a later full frame with EN=1 is received. Assert HRESETn mid-frame → all registers return to reset values (PRESCALE=868).

Source files
------------

// File: rtl/ahbl_uart_rx.sv
// AHB-Lite UART receiver: 8N1 serial input, receive FIFO, level interrupt.
// Registers: DATA (pop on read), STATUS (W1C sticky flags), CTRL, PRESCALE.
module ahbl_uart_rx #(
   parameter int          FIFO_DEPTH   = 16,
   parameter logic [15:0] DEF_PRESCALE = 16'd868
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic [2:0]  HSIZE,
   input  logic        HWRITE,
   input  logic        HREADY,
   input  logic [31:0] HWDATA,
   output logic        HREADYOUT,
   output logic [31:0] HRDATA,
   input  logic        rx,
   output logic        IRQ
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;

   state_t         state_q, state_d;
   logic           rx_p0, rx_p1, rx_p2;
   logic           start_edge;
   logic [15:0]    cnt, prescale, presc_eff;
   logic [2:0]     idx;
   logic [7:0]     shift;
   logic           cnt_zero;
   logic           load_half, reload, shift_en, push_req, frame_set;
   logic           en, irq_en, overrun, frame_err, irq_q;
   logic           wr_pend;
   logic [1:0]     wr_addr;
   logic           accept, pop, do_push, full, not_empty;
   logic [7:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [AW:0]    count;
   logic [8:0]     level_ext;
   logic [31:0]    rd_mux;
   logic           unused_ok;

   assign HREADYOUT = 1'b1;
   assign IRQ       = irq_q;
   assign unused_ok = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:16]};

   // Stage p0/p1: metastability synchroniser; p2 holds the previous sample for edge detect
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         rx_p0 <= 1'b1;
         rx_p1 <= 1'b1;
         rx_p2 <= 1'b1;
      end else begin
         rx_p0 <= rx;
         rx_p1 <= rx_p0;
         rx_p2 <= rx_p1;
      end
   end

   assign start_edge = rx_p2 & ~rx_p1;
   assign cnt_zero   = (cnt == 16'd0);
   assign presc_eff  = (prescale < 16'd4) ? 16'd4 : prescale;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:      if (start_edge) state_d = S_START;
            S_START:     if (cnt_zero) state_d = rx_p1 ? S_IDLE : S_DATA;
            S_DATA:      if (cnt_zero && idx == 3'd7) state_d = S_STOP;
            S_STOP:      if (cnt_zero) state_d = rx_p1 ? S_IDLE : S_WAIT_HIGH;
            S_WAIT_HIGH: if (rx_p1) state_d = S_IDLE;
            default:     state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      load_half = en & (state_q == S_IDLE) & start_edge;
      reload    = en & cnt_zero & (((state_q == S_START) & ~rx_p1) | (state_q == S_DATA));
      shift_en  = en & cnt_zero & (state_q == S_DATA);
      push_req  = en & cnt_zero & (state_q == S_STOP) & rx_p1;
      frame_set = en & cnt_zero & (state_q == S_STOP) & ~rx_p1;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         cnt <= 16'd0;
         idx <= 3'd0;
      end else begin
         if (load_half)         cnt <= presc_eff >> 1;
         else if (reload)       cnt <= presc_eff - 16'd1;
         else if (!cnt_zero)    cnt <= cnt - 16'd1;
         if (state_q == S_START) idx <= 3'd0;
         else if (shift_en)      idx <= idx + 3'd1;
      end
   end

   // LSB-first: the first data bit ends up in bit 0 after eight shifts
   always_ff @(posedge HCLK) begin
      if (shift_en) shift <= {rx_p1, shift[7:1]};
   end

   assign accept    = HSEL & HREADY & HTRANS[1];
   assign not_empty = (count != '0);
   assign full      = (count == DEPTH_L);
   assign pop       = accept & ~HWRITE & (HADDR[3:2] == 2'd0) & not_empty;
   assign do_push   = push_req & (~full | pop);
   assign level_ext = 9'(count);

   always_ff @(posedge HCLK) begin
      if (do_push) mem[wr_ptr] <= shift;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      rd_mux = 32'd0;
      case (HADDR[3:2])
         2'd0: if (not_empty) rd_mux = {24'd0, mem[rd_ptr]};
         2'd1: rd_mux = {19'd0, level_ext, frame_err, overrun, full, not_empty};
         2'd2: rd_mux = {30'd0, irq_en, en};
         default: rd_mux = {16'd0, prescale};
      endcase
   end

   // Address phase captures control and read data; the write lands one cycle later
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_pend   <= 1'b0;
         wr_addr   <= 2'd0;
         HRDATA    <= 32'd0;
         en        <= 1'b0;
         irq_en    <= 1'b0;
         prescale  <= DEF_PRESCALE;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         wr_pend <= accept & HWRITE;
         if (accept) wr_addr <= HADDR[3:2];
         if (accept && !HWRITE) HRDATA <= rd_mux;
         if (wr_pend && wr_addr == 2'd2) {irq_en, en} <= HWDATA[1:0];
         if (wr_pend && wr_addr == 2'd3) prescale <= HWDATA[15:0];
         // A new event wins over a simultaneous clear so it is never lost
         if (push_req && full && !pop)                     overrun <= 1'b1;
         else if (wr_pend && wr_addr == 2'd1 && HWDATA[2]) overrun <= 1'b0;
         if (frame_set)                                    frame_err <= 1'b1;
         else if (wr_pend && wr_addr == 2'd1 && HWDATA[3]) frame_err <= 1'b0;
         irq_q <= irq_en & (not_empty | overrun | frame_err);
      end
   end

endmodule

// File: tb/tb_ahbl_uart_rx.sv
// Directed/randomised bench for ahbl_uart_rx against a byte-queue model of the
// receive FIFO and its sticky flags.
module tb_ahbl_uart_rx;

   localparam int DEPTH = 16;
   localparam int P     = 16;
   localparam int A_NONE = 0, A_POP = 1, A_DIS = 2, A_RST = 3;
   // Cycle (from the start-bit drive) whose address phase coincides with the stop-bit push
   localparam int PUSH_CYC = 3 + P / 2 + 9 * P;

   logic        HCLK, HRESETn, HSEL, HWRITE, HREADY, HREADYOUT, rx, IRQ;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;

   ahbl_uart_rx #(.FIFO_DEPTH(DEPTH), .DEF_PRESCALE(16'd868)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
      .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .rx(rx), .IRQ(IRQ)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  q[$];
   logic        m_ov = 1'b0;
   logic        m_fe = 1'b0;
   logic [31:0] rd, pop_data, exp_w;
   logic [7:0]  b, head;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_status();
      logic [8:0] lvl;
      lvl = 9'(q.size());
      return {19'd0, lvl, m_fe, m_ov, (q.size() == DEPTH), (q.size() != 0)};
   endfunction

   task automatic model_push(input logic [7:0] v);
      if (q.size() == DEPTH) m_ov = 1'b1;
      else q.push_back(v);
   endtask

   function automatic logic [31:0] exp_pop();
      if (q.size() == 0) return 32'd0;
      return {24'd0, q.pop_front()};
   endfunction

   task automatic bus_idle();
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'd0;
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
      @(negedge HCLK);
      bus_idle();
      HWDATA = data;
      @(negedge HCLK);
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
      @(negedge HCLK);
      bus_idle();
      data = HRDATA;
   endtask

   // Drives one 8N1 frame at P clocks per bit; stop_low > 0 holds the stop bit low
   // for that many bit times. An optional bus/reset action is injected at act_cyc.
   task automatic send_frame(input logic [7:0] v, input int stop_low, input int act, input int act_cyc);
      int total;
      total = 10 * P + stop_low * P;
      for (int c = 0; c < total; c++) begin
         if (c < P)                       rx = 1'b0;
         else if (c < 9 * P)              rx = v[c / P - 1];
         else if (c < 9 * P + stop_low * P) rx = 1'b0;
         else                             rx = 1'b1;
         if (c == act_cyc) begin
            case (act)
               A_POP: begin HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0; end
               A_DIS: begin HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h8; end
               A_RST: HRESETn = 1'b0;
               default: ;
            endcase
         end
         if (c == act_cyc + 1) begin
            case (act)
               A_POP: begin bus_idle(); pop_data = HRDATA; end
               A_DIS: begin bus_idle(); HWDATA = 32'h2; end
               A_RST: begin
                  check("rst_mid_hrdata", HRDATA, 32'd0);
                  check("rst_mid_irq", {31'd0, IRQ}, 32'd0);
               end
               default: ;
            endcase
         end
         if (act == A_RST && c == act_cyc + 3) HRESETn = 1'b1;
         @(negedge HCLK);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      HRESETn = 1'b0; HREADY = 1'b1; HSIZE = 3'd2; HWDATA = 32'd0; rx = 1'b1;
      bus_idle();
      repeat (3) @(negedge HCLK);
      check("reset_hrdata", HRDATA, 32'd0);
      check("reset_irq", {31'd0, IRQ}, 32'd0);
      check("hreadyout", {31'd0, HREADYOUT}, 32'd1);
      HRESETn = 1'b1;
      @(negedge HCLK);
      bus_read(32'h8, rd); check("reset_ctrl", rd, 32'd0);
      bus_read(32'hC, rd); check("reset_prescale", rd, 32'd868);
      bus_read(32'h4, rd); check("reset_status", rd, exp_status());

      bus_write(32'hC, P);
      bus_write(32'h8, 32'h3);
      bus_read(32'hC, rd); check("prescale_rb", rd, P);
      bus_read(32'h8, rd); check("ctrl_rb", rd, 32'h3);

      // Basic receive of 0xA5
      send_frame(8'hA5, 0, A_NONE, -2);
      model_push(8'hA5);
      bus_read(32'h4, rd); check("basic_status", rd, 32'h11);
      check("basic_irq_hi", {31'd0, IRQ}, 32'd1);
      bus_read(32'h0, rd); check("basic_data", rd, exp_pop());
      check("irq_lag", {31'd0, IRQ}, 32'd1);
      bus_read(32'h4, rd); check("basic_status_empty", rd, exp_status());
      check("basic_irq_lo", {31'd0, IRQ}, 32'd0);

      // Random bytes
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom);
         send_frame(b, 0, A_NONE, -2);
         model_push(b);
      end
      for (int i = 0; i < 3; i++) begin
         exp_w = exp_pop();
         bus_read(32'h0, rd); check("rand_data", rd, exp_w);
      end

      // Fill past capacity
      for (int i = 0; i < DEPTH + 1; i++) begin
         send_frame(8'(i), 0, A_NONE, -2);
         model_push(8'(i));
      end
      bus_read(32'h4, rd); check("fill_status", rd, exp_status());
      for (int i = 0; i < DEPTH + 1; i++) begin
         exp_w = exp_pop();
         bus_read(32'h0, rd); check("fill_data", rd, exp_w);
      end
      bus_read(32'h4, rd); check("drain_status", rd, exp_status());
      bus_write(32'h4, 32'h4); m_ov = 1'b0;
      bus_read(32'h4, rd); check("ovr_clear", rd, exp_status());

      // Framing error then recovery
      send_frame(8'h3C, 2, A_NONE, -2);
      m_fe = 1'b1;
      bus_read(32'h4, rd); check("fe_status", rd, exp_status());
      check("fe_irq", {31'd0, IRQ}, 32'd1);
      send_frame(8'h55, 0, A_NONE, -2);
      model_push(8'h55);
      bus_read(32'h4, rd); check("fe_recover_status", rd, exp_status());
      bus_read(32'h0, rd); check("fe_recover_data", rd, 32'h55);
      void'(exp_pop());
      bus_write(32'h4, 32'h8); m_fe = 1'b0;
      bus_read(32'h4, rd); check("fe_clear", rd, exp_status());

      // False start glitch
      rx = 1'b0;
      repeat (3) @(negedge HCLK);
      rx = 1'b1;
      repeat (40) @(negedge HCLK);
      bus_read(32'h4, rd); check("glitch_status", rd, exp_status());
      check("glitch_irq", {31'd0, IRQ}, 32'd0);

      // Push and pop in the same cycle while full
      for (int i = 0; i < DEPTH; i++) begin
         b = 8'($urandom);
         send_frame(b, 0, A_NONE, -2);
         model_push(b);
      end
      bus_read(32'h4, rd); check("full_status", rd, exp_status());
      b = 8'($urandom);
      head = q.pop_front();
      q.push_back(b);
      send_frame(b, 0, A_POP, PUSH_CYC);
      check("simul_pop_data", pop_data, {24'd0, head});
      bus_read(32'h4, rd); check("simul_status", rd, exp_status());
      for (int i = 0; i < DEPTH; i++) begin
         exp_w = exp_pop();
         bus_read(32'h0, rd); check("simul_drain", rd, exp_w);
      end

      // Disable during bit 4
      send_frame(8'h77, 0, A_DIS, 5 * P + 8);
      bus_read(32'h4, rd); check("dis_status", rd, exp_status());
      bus_read(32'h8, rd); check("dis_ctrl", rd, 32'h2);
      bus_write(32'h8, 32'h3);
      b = 8'($urandom);
      send_frame(b, 0, A_NONE, -2);
      model_push(b);
      exp_w = exp_pop();
      bus_read(32'h0, rd); check("reen_data", rd, exp_w);

      // Asynchronous reset mid-frame with a byte already queued
      b = 8'($urandom);
      send_frame(b, 0, A_NONE, -2);
      model_push(b);
      check("pre_rst_irq", {31'd0, IRQ}, 32'd1);
      send_frame(8'($urandom), 0, A_RST, 60);
      q.delete(); m_ov = 1'b0; m_fe = 1'b0;
      bus_read(32'hC, rd); check("post_rst_prescale", rd, 32'd868);
      bus_read(32'h8, rd); check("post_rst_ctrl", rd, 32'd0);
      bus_read(32'h4, rd); check("post_rst_status", rd, exp_status());
      check("post_rst_irq", {31'd0, IRQ}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
